prog_sequencer: RTL
===================

// Module: prog_sequencer
// PURPOSE
//  Host-side launcher driving the processor's Start/Done handshake (initiator end of the PC's Start input).
//  - On Go, runs programs 0..NUM_PROGS-1 in order.
//  - Each program gets exactly one 1-cycle Start pulse; the PC advances its program-select count once per Start-high cycle.
//  - Waits for the processor's Done, records the run length in cycles, then launches the next program.
//  - Sits between the top-level test harness and the processor core.
// PARAMETERS
//  NUM_PROGS    3      programs to launch per sequence (1..3; must match the PC's hardcoded entry table)
//  GAP_CYC      2      idle cycles between Done and the next Start pulse (>=1)
//  TIMEOUT_CYC  4000   max RUN cycles per program before abort (< 2**CYC_W)
//  CYC_W        16     width of cycle counter
// PORTS
//  Clk         in   1      clock; all state changes on posedge
//  Reset       in   1      asynchronous, active-low reset
//  Go          in   1      request to start a full sequence; sampled only in IDLE
//  Done        in   1      processor program-complete flag; sampled only in RUN
//  Start       out  1      to processor/PC; 1-cycle pulse per program launch
//  ProgIdx     out  2      index of the program currently launched/running
//  Busy        out  1      high in LAUNCH, RUN, GAP
//  CycleCount  out  CYC_W  run length of the most recently completed program
//  CountValid  out  1      1-cycle pulse when CycleCount updates
//  Timeout     out  1      sticky; set when a program exceeds TIMEOUT_CYC
//  AllDone     out  1      sticky; set when the sequence ends (normally or by timeout)
// BEHAVIOUR
//  Reset (Reset==0, async, any state, including mid-run):
//   - State=IDLE.
//   - Start=0, ProgIdx=0, Busy=0, CycleCount=0, CountValid=0, Timeout=0, AllDone=0.
//   - Internal run and gap counters = 0.
//  All outputs are registered; no combinational path from Go or Done to any output.
//  States:
//   IDLE:   Go==1 -> LAUNCH with ProgIdx=0. Go==0 -> stay.
//   LAUNCH: exactly one cycle with Start=1; run counter cleared to 0. Next state RUN.
//           Done is ignored in this cycle.
//   RUN:    Start=0; run counter +1 every cycle, including the cycle Done is sampled high.
//           Done==1 -> CycleCount<=run counter+1, CountValid pulses next cycle.
//             If ProgIdx==NUM_PROGS-1 -> FINISH; else -> GAP.
//           Run counter+1 == TIMEOUT_CYC with Done==0 -> Timeout<=1, AllDone<=1, -> FINISH.
//             CycleCount is unchanged; no CountValid pulse.
//           Done and timeout in the same cycle: Done wins (normal completion).
//   GAP:    stay GAP_CYC cycles.
//           Then ProgIdx<=ProgIdx+1, -> LAUNCH.
//           Done ignored.
//   FINISH: AllDone=1, Busy=0, Start=0; terminal until Reset.
//           Go is ignored: the PC's 2-bit start count would wrap, so relaunch requires resetting both blocks.
//  Timing:
//   - Go sampled high in IDLE at edge N -> Start=1 during cycle N+1 only.
//   - Start never high for two consecutive cycles.
//   - Start never high outside LAUNCH.
//   - Exactly NUM_PROGS Start pulses per normal sequence; fewer on timeout.
//  Widths: run counter is CYC_W bits. It cannot wrap, because TIMEOUT_CYC < 2**CYC_W.
//  Go held high across the whole sequence has no extra effect: it is only sampled in IDLE.
//  Done held high from a previous program is not sampled in GAP or LAUNCH.
//   - If still high in the first RUN cycle, it is taken as completion with CycleCount=1.
// TESTING
//  1 Reset low, then release; Go=1 for 1 cycle; Done pulses 10 cycles after each Start
//    -> 3 single-cycle Start pulses, CycleCount=10 three times.
//    Start spacing = 10 + 1 + GAP_CYC(2) = 13 cycles; AllDone=1; Timeout=0.
//  2 Done held high continuously from Go
//    -> each program CycleCount=1; Start pulses 4 cycles apart; AllDone after 3rd.
//  3 Program 1 never raises Done, TIMEOUT_CYC=50
//    -> Timeout=1 and AllDone=1 after 50 RUN cycles; only 2 Start pulses total.
//    CycleCount holds program 0's value.
//  4 Done asserted exactly on the cycle run counter reaches TIMEOUT_CYC-1
//    -> normal completion, CycleCount=TIMEOUT_CYC, Timeout=0.
//  5 Reset driven low during RUN of program 1, asynchronously mid-cycle
//    -> all outputs 0 immediately.
//    After release, Go restarts at ProgIdx=0.
//  6 Go pulsed during RUN and in FINISH
//    -> no extra Start pulse; state and outputs unchanged.

Source files
------------

// File: rtl/prog_sequencer.sv
// Host-side launcher for the processor's Start/Done handshake: runs programs
// 0..NUM_PROGS-1 in order, measuring each program's run length in cycles.
//
// state  | meaning
// IDLE   | waiting for Go
// LAUNCH | single cycle with Start high, run counter cleared
// RUN    | counting cycles until Done or timeout
// GAP    | idle spacing before the next launch (down-counter)
// FINISH | sequence over; AllDone held until reset
module prog_sequencer #(
  parameter int NUM_PROGS   = 3,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 4000,
  parameter int CYC_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Go,
  input  logic             Done,
  output logic             Start,
  output logic [1:0]       ProgIdx,
  output logic             Busy,
  output logic [CYC_W-1:0] CycleCount,
  output logic             CountValid,
  output logic             Timeout,
  output logic             AllDone
);

  localparam logic [CYC_W-1:0] TIMEOUT_V = CYC_W'(TIMEOUT_CYC);
  localparam logic [CYC_W-1:0] GAP_LOAD  = CYC_W'(GAP_CYC - 1);
  localparam logic [1:0]       LAST_IDX  = 2'(NUM_PROGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_GAP,
    S_FINISH
  } state_t;

  state_t           state;
  logic [CYC_W-1:0] run_cnt;
  logic [CYC_W-1:0] gap_cnt;
  logic [CYC_W-1:0] run_next;

  // Count includes the cycle in which Done is sampled.
  assign run_next = run_cnt + CYC_W'(1);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      run_cnt    <= '0;
      gap_cnt    <= '0;
      Start      <= 1'b0;
      ProgIdx    <= 2'd0;
      Busy       <= 1'b0;
      CycleCount <= '0;
      CountValid <= 1'b0;
      Timeout    <= 1'b0;
      AllDone    <= 1'b0;
    end else begin
      Start      <= 1'b0;
      CountValid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Go) begin
            state   <= S_LAUNCH;
            Start   <= 1'b1;
            ProgIdx <= 2'd0;
            Busy    <= 1'b1;
          end
        end
        S_LAUNCH: begin
          run_cnt <= '0;
          state   <= S_RUN;
        end
        S_RUN: begin
          run_cnt <= run_next;
          if (Done) begin
            CycleCount <= run_next;
            CountValid <= 1'b1;
            if (ProgIdx == LAST_IDX) begin
              state   <= S_FINISH;
              AllDone <= 1'b1;
              Busy    <= 1'b0;
            end else begin
              state   <= S_GAP;
              gap_cnt <= GAP_LOAD;
            end
          end else if (run_next == TIMEOUT_V) begin
            Timeout <= 1'b1;
            AllDone <= 1'b1;
            Busy    <= 1'b0;
            state   <= S_FINISH;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            ProgIdx <= ProgIdx + 2'd1;
            Start   <= 1'b1;
            state   <= S_LAUNCH;
          end else begin
            gap_cnt <= gap_cnt - CYC_W'(1);
          end
        end
        S_FINISH: begin
          // Relaunch needs a reset so the PC's start count stays aligned.
          state <= S_FINISH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
